// File: rtl/usb_cmd_master.sv
// rtl/usb_cmd_master.sv - FX3 GPIF2 bridge control-protocol initiator
module usb_cmd_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_size,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic [31:0] ctrl_tdata,
  output logic        ctrl_tvalid,
  input  logic        ctrl_tready,
  output logic        ctrl_tlast,
  output logic [31:0] tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  input  logic [31:0] rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  input  logic        rx_tlast,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] TYPE_IN  = 8'h40;
  localparam logic [7:0] TYPE_OUT = 8'h80;

  typedef enum logic [2:0] {IDLE, CMD0, CMD1, CMD2, DOUT, DIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] size_q, size_d;
  logic [29:0] words_left_q, words_left_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic        last_word;

  // A request is only worth serialising if the bridge can decode it.
  assign req_ok    = (req_size[1:0] == 2'b00) && (req_size != 32'd0) &&
                     ((req_type == TYPE_IN) || (req_type == TYPE_OUT));
  assign last_word = (words_left_q == 30'd1);

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  // Next-state logic plus the per-state multiplexing of the three stream ports.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    addr_d       = addr_q;
    size_d       = size_q;
    words_left_d = words_left_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    req_ready    = 1'b0;
    ctrl_tdata   = 32'd0;
    ctrl_tvalid  = 1'b0;
    ctrl_tlast   = 1'b0;
    tx_tdata     = 32'd0;
    tx_tvalid    = 1'b0;
    tx_tlast     = 1'b0;
    wr_ready     = 1'b0;
    rd_data      = 32'd0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    rx_tready    = 1'b0;

    case (state_q)
      IDLE: begin
        // Held low while in reset so the client never sees a phantom accept.
        req_ready = ~rst;
        if (req_valid && !rst) begin
          type_d       = req_type;
          addr_d       = req_addr;
          size_d       = req_size;
          words_left_d = req_size[31:2];
          if (req_ok) begin
            state_d = CMD0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CMD0: begin
        ctrl_tvalid = 1'b1;
        ctrl_tdata  = size_q;
        if (ctrl_tready) state_d = CMD1;
      end
      CMD1: begin
        ctrl_tvalid = 1'b1;
        ctrl_tdata  = addr_q;
        if (ctrl_tready) state_d = CMD2;
      end
      CMD2: begin
        ctrl_tvalid = 1'b1;
        ctrl_tdata  = {24'h0, type_q};
        ctrl_tlast  = 1'b1;
        if (ctrl_tready) state_d = (type_q == TYPE_OUT) ? DOUT : DIN;
      end
      DOUT: begin
        tx_tdata  = wr_data;
        tx_tvalid = wr_valid;
        tx_tlast  = last_word;
        wr_ready  = tx_tready;
        if (wr_valid && tx_tready) begin
          words_left_d = words_left_q - 30'd1;
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DIN: begin
        rd_data   = rx_tdata;
        rd_valid  = rx_tvalid;
        rd_last   = last_word;
        rx_tready = rd_ready;
        if (rx_tvalid && rd_ready) begin
          words_left_d = words_left_q - 30'd1;
          if (last_word) begin
            // Count reached: finish, but flag a bridge that forgot its marker.
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = ~rx_tlast;
          end else if (rx_tlast) begin
            // Bridge ended the transfer short: deliver the beat, abort.
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset returns to IDLE with no pending pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      type_q       <= 8'd0;
      addr_q       <= 32'd0;
      size_q       <= 32'd0;
      words_left_q <= 30'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      words_left_q <= words_left_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/usb_cmd_master.md
# usb_cmd_master

On-chip initiator for the FX3 GPIF2 bridge's three-word control protocol. It serialises a request (type, address, size) into the control-stream words the bridge decodes, then moves the payload: it streams OUT data toward the bridge, or collects IN data from it. It sits between an on-chip client (self-test engine or loopback bench) and the bridge's four AXI-stream FIFOs, in place of the FX3 host side.

## Interface
Parameters: none; all widths fixed by the protocol.

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_type  in  8  0x40 IN_RX, 0x80 OUT_TX
- req_addr  in  32  transfer start address
- req_size  in  32  byte count; multiple of 4, ≥4
- wr_data  in  32  OUT payload from client
- wr_valid  in  1  OUT payload valid
- wr_ready  out  1  OUT payload consumed
- rd_data  out  32  IN payload to client
- rd_valid  out  1  IN payload valid
- rd_ready  in  1  client accepts IN payload
- rd_last  out  1  final IN word
- ctrl_tdata  out  32  control word to bridge
- ctrl_tvalid  out  1  control word valid
- ctrl_tready  in  1  bridge accepts control word
- ctrl_tlast  out  1  high on third control word
- tx_tdata  out  32  OUT data to bridge
- tx_tvalid  out  1  OUT data valid
- tx_tready  in  1  bridge accepts OUT data
- tx_tlast  out  1  final OUT word
- rx_tdata  in  32  IN data from bridge
- rx_tvalid  in  1  IN data valid
- rx_tready  out  1  IN data accepted
- rx_tlast  in  1  bridge end-of-transfer marker
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on transfer completion
- err  out  1  one-cycle pulse on rejected request or framing error

## Operation
- States: IDLE, CMD0, CMD1, CMD2, DOUT, DIN.
- IDLE: req_ready=1. On handshake, latch type/addr/size and set words_left = size[31:2].
  - If the size is invalid (size[1:0]≠0 or size==0), or type is not 0x40/0x80: the request is consumed and nothing is sent. err pulses; stay IDLE.
- CMD0: ctrl_tdata = size. CMD1: ctrl_tdata = addr. CMD2: ctrl_tdata = {24'h0, type}, ctrl_tlast=1.
  - Each state advances only on ctrl_tvalid & ctrl_tready.
  - Data is held stable while stalled.
- After CMD2 handshake: type 0x80 → DOUT; type 0x40 → DIN.
- DOUT: combinational pass-through, tx_tdata=wr_data, tx_tvalid=wr_valid, wr_ready=tx_tready.
  - tx_tlast = (words_left==1).
  - Each beat decrements words_left.
  - The last beat → IDLE and done pulses.
- DIN: rd_data=rx_tdata, rd_valid=rx_tvalid, rx_tready=rd_ready, rd_last=(words_left==1).
  - Each beat decrements words_left.
  - Last counted beat → IDLE and done pulses. If rx_tlast is absent on that beat, err also pulses.
  - rx_tlast on an earlier beat → IDLE and err pulses (no done). The beat is still delivered to the client.
- Outside their state, all pass-through valids/readies are 0.
- words_left is 30 bits; size 0xFFFFFFFC gives 0x3FFFFFFF words with no wrap.

## Timing
- Reset values: req_ready=0 while rst high, 1 the first cycle after.
  - All other outputs are 0 during reset; state IDLE; words_left 0.
- Request handshake at cycle N → ctrl_tvalid=1 with word0 at N+1.
  - Minimum command phase: 3 cycles with ctrl_tready held high.
- First data beat is eligible the cycle after the CMD2 handshake. Throughput is 1 word/cycle when unstalled.
- done/err assert the cycle after the final handshake, for exactly 1 cycle. busy falls that same cycle.
- Reset mid-transfer: all valids/readies drop the next edge with no trailing tlast. The bridge-side transfer is left to the bridge's own length counter.

## Test plan
- OUT 4 bytes: req(0x80, 0x0, 4), all readies high.
  - ctrl words 4, 0, 0x80 (tlast on 3rd), then one tx beat.
  - wr_data 0x8F8E8D8C appears with tx_tlast=1; done one cycle later.
- IN 8 bytes: req(0x40, 0x100, 8), rx supplies 0x11111111 then 0x22222222 with tlast on the 2nd.
  - rd_last on the 2nd word; done=1, err=0.
- Backpressure: ctrl_tready toggles 1/0 and tx_tready low for 3 cycles mid-OUT 16 bytes.
  - No word lost or duplicated; ctrl_tdata stable while stalled; exactly 4 tx beats.
- Invalid requests: size 6, size 0, type 0x00.
  - Each produces an err pulse, no ctrl_tvalid, and req_ready stays high.
- Early tlast: IN 16 bytes, rx_tlast on beat 2.
  - 2 rd beats delivered, err pulses, done stays low, back to IDLE.
- Reset in DOUT after 1 of 4 beats: next cycle tx_tvalid=0 and busy=0. A following valid request runs normally.
